freq_strobe_gen: RTL

Consumer end of the 32-bit frequency word produced by the key-controlled frequency adjuster. It turns a requested frequency in Hz into an exact-average-rate, single-cycle strobe in the system clock domain, plus a 50%-duty square wave at half the strobe rate. The strobe paces the downstream tone/sample logic. Frequency changes use a load/ack handshake and take effect only at a strobe boundary, so the output never glitches.

---
 rtl/freq_strobe_gen_pkg.sv | 23 ++
 rtl/freq_strobe_gen_clamp.sv | 14 +
 rtl/freq_strobe_gen.sv | 84 ++++++++
 3 files changed

// File: rtl/freq_strobe_gen_pkg.sv
// rtl/freq_strobe_gen_pkg.sv - shared state type, width helper and clamp for freq_strobe_gen
package freq_strobe_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    function automatic int acc_width(input longint unsigned clk_hz, input longint unsigned f_max);
        return $clog2(clk_hz + f_max) + 1;
    endfunction

    localparam int ACC_W = acc_width(50_000_000, 25_000_000);

    function automatic logic [31:0] clamp(input logic [31:0] x, input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/freq_strobe_gen_clamp.sv
// rtl/freq_strobe_gen_clamp.sv - combinational clamp of a requested frequency into [F_MIN, F_MAX]
module freq_clamp
    import freq_strobe_gen_pkg::*;
#(
    parameter int unsigned F_MIN = 1,
    parameter int unsigned F_MAX = 25_000_000
) (
    input  logic [31:0] freq,
    output logic [31:0] freq_clamped
);

    assign freq_clamped = clamp(freq, F_MIN, F_MAX);

endmodule

// File: rtl/freq_strobe_gen.sv
// rtl/freq_strobe_gen.sv - phase-accumulator strobe generator with glitch-free frequency handover
module freq_strobe_gen
    import freq_strobe_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned F_MIN  = 1,
    parameter int unsigned F_MAX  = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] freq_in,
    input  logic        freq_load,
    output logic        freq_ack,
    output logic [31:0] freq_active,
    output logic        strobe,
    output logic        square
);

    localparam int W = acc_width(CLK_HZ, F_MAX);
    localparam logic [W-1:0] MODULUS = W'(CLK_HZ);

    state_t       state;
    logic [W-1:0] acc;
    logic [31:0]  pending;
    logic [31:0]  freq_new;
    logic [W-1:0] nxt;
    logic         hit;

    freq_clamp #(.F_MIN(F_MIN), .F_MAX(F_MAX)) u_clamp (
        .freq         (freq_in),
        .freq_clamped (freq_new)
    );

    assign nxt = acc + W'(freq_active);
    assign hit = (nxt >= MODULUS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            pending     <= '0;
            strobe      <= 1'b0;
            square      <= 1'b0;
            freq_ack    <= 1'b0;
            freq_active <= clamp(F_MIN, F_MIN, F_MAX);
        end else begin
            freq_ack <= 1'b0;
            if (!en) begin
                state  <= IDLE;
                acc    <= '0;
                strobe <= 1'b0;
                square <= 1'b0;
                // A fresh load beats a waiting one; either way only one ack.
                if (freq_load) begin
                    freq_active <= freq_new;
                    freq_ack    <= 1'b1;
                end else if (state == PENDING) begin
                    freq_active <= pending;
                    freq_ack    <= 1'b1;
                end
            end else begin
                acc    <= hit ? (nxt - MODULUS) : nxt;
                strobe <= hit;
                if (hit) square <= ~square;
                if (state == PENDING) begin
                    if (hit) begin
                        freq_active <= freq_load ? freq_new : pending;
                        freq_ack    <= 1'b1;
                        state       <= RUN;
                    end else if (freq_load) begin
                        pending <= freq_new;
                    end
                end else if (freq_load) begin
                    pending <= freq_new;
                    state   <= PENDING;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule
